// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter types and the control bundle carried
// alongside each pixel through the framebuffer read pipeline.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  localparam int COUNT_W = 10;

  typedef logic [COUNT_W-1:0] h_count_t;
  typedef logic [COUNT_W-1:0] v_count_t;

  typedef struct packed {
    logic active;
    logic inImg;
    logic hsyncN;
    logic vsyncN;
    logic frameStart;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{
    active:     1'b0,
    inImg:      1'b0,
    hsyncN:     1'b1,
    vsyncN:     1'b1,
    frameStart: 1'b0
  };

  // Half-open interval test [lo, hi).
  function automatic logic inRange(input int value, input int lo, input int hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a synchronous reset value; aligns the
// control bundle with data returned by the framebuffer memory.
module sync_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  if (DEPTH < 1) begin : gen_badDepth
    $error("sync_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain; reset fills every stage with the idle value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RESET_VALUE;
      end
    end else begin
      stage_r[0] <= dataIn;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dataOut = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_framebuffer_scanner.sv
// VGA raster generator that reads a centred grayscale image window from the
// framebuffer's second read port and drives the ADV7123 DAC pins.
module vga_framebuffer_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter int IMG_W        = 256,
  parameter int IMG_H        = 256,
  parameter int IMG_X0       = 192,
  parameter int IMG_Y0       = 112,
  parameter int IMG_BASE     = 0,
  parameter int ADDR_W       = 17,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        color,
  output logic [ADDR_W-1:0] address_vga,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic              frame_start
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam h_count_t          H_LAST        = h_count_t'(H_TOT - 1);
  localparam v_count_t          V_LAST        = v_count_t'(V_TOT - 1);
  localparam logic [ADDR_W-1:0] IMG_ADDR_BASE = ADDR_W'(IMG_BASE);

  if (IMG_X0 + IMG_W > H_ACTIVE) begin : gen_badImgX
    $error("vga_framebuffer_scanner: image window exceeds visible width");
  end
  if (IMG_Y0 + IMG_H > V_ACTIVE) begin : gen_badImgY
    $error("vga_framebuffer_scanner: image window exceeds visible height");
  end
  if (READ_LATENCY < 1) begin : gen_badLatency
    $error("vga_framebuffer_scanner: READ_LATENCY must be at least 1");
  end
  if ((H_TOT > (1 << COUNT_W)) || (V_TOT > (1 << COUNT_W))) begin : gen_badTotals
    $error("vga_framebuffer_scanner: line or frame too long for counters");
  end

  h_count_t          hCount_r;
  v_count_t          vCount_r;
  logic [ADDR_W-1:0] pixIndex_r;
  logic [ADDR_W-1:0] address_r;
  logic              lineEnd_s;
  logic              frameEnd_s;
  vga_ctrl_t         ctrl_s;
  vga_ctrl_t         ctrlDly_s;
  logic [7:0]        gray_s;
  logic [7:0]        gray_r;
  logic              hsync_r;
  logic              vsync_r;
  logic              blankN_r;
  logic              frameStart_r;

  // Raster position decode for the current counter value.
  always_comb begin
    lineEnd_s         = (hCount_r == H_LAST);
    frameEnd_s        = lineEnd_s && (vCount_r == V_LAST);
    ctrl_s.active     = (int'(hCount_r) < H_ACTIVE) && (int'(vCount_r) < V_ACTIVE);
    ctrl_s.inImg      = inRange(int'(hCount_r), IMG_X0, IMG_X0 + IMG_W) &&
                        inRange(int'(vCount_r), IMG_Y0, IMG_Y0 + IMG_H);
    ctrl_s.hsyncN     = !inRange(int'(hCount_r), HS_START, HS_END);
    ctrl_s.vsyncN     = !inRange(int'(vCount_r), VS_START, VS_END);
    ctrl_s.frameStart = (hCount_r == h_count_t'(0)) && (vCount_r == v_count_t'(0));
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hCount_r <= h_count_t'(0);
      vCount_r <= v_count_t'(0);
    end else if (lineEnd_s) begin
      hCount_r <= h_count_t'(0);
      vCount_r <= frameEnd_s ? v_count_t'(0) : vCount_r + v_count_t'(1);
    end else begin
      hCount_r <= hCount_r + h_count_t'(1);
    end
  end

  // Linear pixel index runs across line ends, so no row*width product is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixIndex_r <= {ADDR_W{1'b0}};
      address_r  <= IMG_ADDR_BASE;
    end else begin
      if (frameEnd_s) begin
        pixIndex_r <= {ADDR_W{1'b0}};
      end else if (ctrl_s.inImg) begin
        pixIndex_r <= pixIndex_r + ADDR_W'(1);
      end
      if (ctrl_s.inImg) begin
        address_r <= IMG_ADDR_BASE + pixIndex_r;
      end
    end
  end

  assign address_vga = address_r;

  // One stage covers the address register, the rest cover the memory read.
  sync_delay_line #(
    .WIDTH      ($bits(vga_ctrl_t)),
    .DEPTH      (READ_LATENCY + 1),
    .RESET_VALUE(CTRL_IDLE)
  ) u_ctrlDelay (
    .clk    (clk),
    .reset  (reset),
    .dataIn (ctrl_s),
    .dataOut(ctrlDly_s)
  );

  // Pixel masking: black outside the image window and during blanking.
  always_comb begin
    if (ctrlDly_s.active && ctrlDly_s.inImg) begin
      gray_s = color;
    end else begin
      gray_s = 8'h00;
    end
  end

  // Pin register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      gray_r       <= 8'h00;
      hsync_r      <= 1'b1;
      vsync_r      <= 1'b1;
      blankN_r     <= 1'b0;
      frameStart_r <= 1'b0;
    end else begin
      gray_r       <= gray_s;
      hsync_r      <= ctrlDly_s.hsyncN;
      vsync_r      <= ctrlDly_s.vsyncN;
      blankN_r     <= ctrlDly_s.active;
      frameStart_r <= ctrlDly_s.frameStart;
    end
  end

  assign vga_r       = gray_r;
  assign vga_g       = gray_r;
  assign vga_b       = gray_r;
  assign vga_hsync   = hsync_r;
  assign vga_vsync   = vsync_r;
  assign vga_blank_n = blankN_r;
  assign vga_sync_n  = 1'b0;
  assign frame_start = frameStart_r;

endmodule

// File: tb/tb_vga_framebuffer_scanner.sv
// Scoreboard bench: three scanner instances (default timing, a scaled-down
// raster, and the scaled raster with a wrapping base address).
module tb_vga_framebuffer_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [16:0] addrD, addrS, addrW;
  logic [7:0]  colorD, colorS, colorW;
  logic [7:0]  rD, gD, bD, rS, gS, bS, rW, gW, bW;
  logic        hsD, vsD, blD, snD, fsD;
  logic        hsS, vsS, blS, snS, fsS;
  logic        hsW, vsW, blW, snW, fsW;

  vga_framebuffer_scanner dutDef (
    .clk(clk), .reset(reset), .color(colorD), .address_vga(addrD),
    .vga_r(rD), .vga_g(gD), .vga_b(bD), .vga_hsync(hsD), .vga_vsync(vsD),
    .vga_blank_n(blD), .vga_sync_n(snD), .frame_start(fsD));

  vga_framebuffer_scanner #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(16), .IMG_H(32), .IMG_X0(24), .IMG_Y0(8)
  ) dutSmall (
    .clk(clk), .reset(reset), .color(colorS), .address_vga(addrS),
    .vga_r(rS), .vga_g(gS), .vga_b(bS), .vga_hsync(hsS), .vga_vsync(vsS),
    .vga_blank_n(blS), .vga_sync_n(snS), .frame_start(fsS));

  vga_framebuffer_scanner #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(16), .IMG_H(32), .IMG_X0(24), .IMG_Y0(8), .IMG_BASE('h1FF00)
  ) dutWrap (
    .clk(clk), .reset(reset), .color(colorW), .address_vga(addrW),
    .vga_r(rW), .vga_g(gW), .vga_b(bW), .vga_hsync(hsW), .vga_vsync(vsW),
    .vga_blank_n(blW), .vga_sync_n(snW), .frame_start(fsW));

  // One-cycle-latency memories returning the low address byte.
  always @(posedge clk) begin
    colorD <= addrD[7:0];
    colorS <= addrS[7:0];
    colorW <= addrW[7:0];
  end

  localparam int S_RGB = 0, S_ADDR = 1, S_HS = 2, S_VS = 3, S_BLANK = 4, S_FS = 5;
  localparam int W_ADDR = 6, W_RGB = 7, D_BLANK = 8, D_HS = 9, D_FS = 10;
  localparam int D_ADDR = 11, D_RGB = 12, D_VS = 13;
  string sigName [14] = '{"small_rgb", "small_addr", "small_hsync", "small_vsync",
                          "small_blank_n", "small_frame_start", "wrap_addr", "wrap_rgb",
                          "def_blank_n", "def_hsync", "def_frame_start", "def_addr",
                          "def_rgb", "def_vsync"};

  typedef struct {
    int cyc;
    int sig;
    int exp;
  } exp_t;
  exp_t q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0, nextCyc = 0, epoch = 0, resetCnt = 0;
  bit inReset = 1'b1;
  bit prevBlank, prevHs, prevVs, blankRoseInLine;
  int lastBlankRise, hsFallCyc, vsFallCyc, lastFs;
  int hsRuns = 0, vsRuns = 0, fsCount = 0, offsetChecks = 0, blankRgbErr = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, epoch %0d)", name, act, exp, cyc, epoch);
    end
  endtask

  task automatic push(input int c, input int s, input int e);
    exp_t item;
    item.cyc = c;
    item.sig = s;
    item.exp = e;
    q.push_back(item);
  endtask

  task automatic pushRgb(input int c, input int s, input int e);
    push(c, s, e * 32'h010101);
  endtask

  function automatic int actualOf(input int sig);
    case (sig)
      S_RGB:   return int'({rS, gS, bS});
      S_ADDR:  return int'(addrS);
      S_HS:    return int'(hsS);
      S_VS:    return int'(vsS);
      S_BLANK: return int'(blS);
      S_FS:    return int'(fsS);
      W_ADDR:  return int'(addrW);
      W_RGB:   return int'({rW, gW, bW});
      D_BLANK: return int'(blD);
      D_HS:    return int'(hsD);
      D_FS:    return int'(fsD);
      D_ADDR:  return int'(addrD);
      D_RGB:   return int'({rD, gD, bD});
      D_VS:    return int'(vsD);
      default: return -1;
    endcase
  endfunction

  task automatic checkResetPins();
    check("rst_def_rgb", int'({rD, gD, bD}), 0);
    check("rst_def_hs_vs_bl_fs", int'({hsD, vsD, blD, fsD, snD}), 5'b11000);
    check("rst_def_addr", int'(addrD), 0);
    check("rst_small_rgb", int'({rS, gS, bS}), 0);
    check("rst_small_hs_vs_bl_fs", int'({hsS, vsS, blS, fsS, snS}), 5'b11000);
    check("rst_small_addr", int'(addrS), 0);
    check("rst_wrap_rgb", int'({rW, gW, bW}), 0);
    check("rst_wrap_hs_vs_bl_fs", int'({hsW, vsW, blW, fsW, snW}), 5'b11000);
    check("rst_wrap_addr", int'(addrW), 'h1FF00);
  endtask

  // Monitor: cycle stamps are counted from each reset release (cycle 0 = counter (0,0)).
  always @(negedge clk) begin
    if (reset) begin
      inReset = 1'b1;
      resetCnt++;
      nextCyc = 0;
      if (resetCnt >= 2) checkResetPins();
    end else begin
      if (inReset) begin
        epoch++;
        inReset = 1'b0;
        resetCnt = 0;
        prevBlank = 1'b0;
        prevHs = 1'b1;
        prevVs = 1'b1;
        blankRoseInLine = 1'b0;
      end
      cyc = nextCyc;
      nextCyc++;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          check(sigName[q[i].sig], actualOf(q[i].sig), q[i].exp);
          q.delete(i);
        end
      end
      if ((!blS && {rS, gS, bS} != 24'h0) || (!blD && {rD, gD, bD} != 24'h0) ||
          (!blW && {rW, gW, bW} != 24'h0)) blankRgbErr++;
      if (epoch == 1 && cyc < 8800) begin
        if (blS && !prevBlank) begin
          lastBlankRise = cyc;
          blankRoseInLine = 1'b1;
        end
        if (!hsS && prevHs) begin
          hsFallCyc = cyc;
          if (blankRoseInLine) begin
            check("hsync_fall_after_blank_rise", cyc - lastBlankRise, 68);
            offsetChecks++;
            blankRoseInLine = 1'b0;
          end
        end
        if (hsS && !prevHs) begin
          check("hsync_low_width", cyc - hsFallCyc, 8);
          hsRuns++;
        end
        if (!vsS && prevVs) vsFallCyc = cyc;
        if (vsS && !prevVs) begin
          check("vsync_low_width", cyc - vsFallCyc, 160);
          vsRuns++;
        end
        if (fsS) begin
          if (fsCount > 0) check("frame_start_period", cyc - lastFs, 4400);
          lastFs = cyc;
          fsCount++;
        end
      end
      prevBlank = blS;
      prevHs = hsS;
      prevVs = vsS;
    end
  end

  initial begin
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    // Scaled raster: 80x55 totals, window x[24,40) y[8,40); pins lag counters by 3.
    push(2, S_FS, 0);      push(3, S_FS, 1);      push(4, S_FS, 0);     push(4403, S_FS, 1);
    push(2, S_BLANK, 0);   push(3, S_BLANK, 1);   push(473, S_BLANK, 0);
    push(667, S_BLANK, 1); push(4013, S_BLANK, 0);
    pushRgb(473, S_RGB, 0);     pushRgb(667, S_RGB, 0);     pushRgb(675, S_RGB, 8);
    pushRgb(683, S_RGB, 0);     pushRgb(1633, S_RGB, 'hC6); pushRgb(2433, S_RGB, 'h66);
    pushRgb(4013, S_RGB, 0);    pushRgb(5066, S_RGB, 0);
    push(70, S_HS, 1);     push(71, S_HS, 0);     push(78, S_HS, 0);    push(79, S_HS, 1);
    push(4002, S_VS, 1);   push(4003, S_VS, 0);   push(4162, S_VS, 0);  push(4163, S_VS, 1);
    push(665, S_ADDR, 0);    push(680, S_ADDR, 15);   push(745, S_ADDR, 16);
    push(1880, S_ADDR, 255); push(1945, S_ADDR, 256); push(3160, S_ADDR, 511);
    push(3611, S_ADDR, 511); push(4406, S_ADDR, 511); push(5065, S_ADDR, 0);
    push(665, W_ADDR, 'h1FF00);  push(1880, W_ADDR, 'h1FFFF); push(1945, W_ADDR, 0);
    push(3160, W_ADDR, 'h000FF); push(5065, W_ADDR, 'h1FF00);
    pushRgb(675, W_RGB, 8); pushRgb(683, W_RGB, 0); pushRgb(1633, W_RGB, 'hC6);
    // Default 800x525 raster, first lines only.
    push(2, D_BLANK, 0);   push(3, D_BLANK, 1);   push(642, D_BLANK, 1);
    push(643, D_BLANK, 0); push(803, D_BLANK, 1);
    push(658, D_HS, 1);    push(659, D_HS, 0);    push(754, D_HS, 0);   push(755, D_HS, 1);
    push(3, D_FS, 1);      push(803, D_FS, 0);
    push(1000, D_ADDR, 0); push(1000, D_VS, 1);   pushRgb(300, D_RGB, 0);

    // Run into frame 3 and reset at scaled counter (30,20), inside the window.
    repeat (10430) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push(2, S_FS, 0);      push(3, S_FS, 1);
    push(0, S_BLANK, 0);   push(1, S_BLANK, 0);   push(2, S_BLANK, 0);  push(3, S_BLANK, 1);
    pushRgb(1, S_RGB, 0);  pushRgb(2, S_RGB, 0);  pushRgb(675, S_RGB, 8);
    push(2, S_HS, 1);      push(70, S_HS, 1);     push(71, S_HS, 0);
    push(1, S_ADDR, 0);    push(665, S_ADDR, 0);  push(680, S_ADDR, 15);
    push(665, W_ADDR, 'h1FF00);
    push(3, D_FS, 1);      push(659, D_HS, 0);

    repeat (700) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    check("hsync_pulses_in_two_frames", hsRuns, 110);
    check("visible_lines_with_hsync_offset", offsetChecks, 96);
    check("vsync_pulses_in_two_frames", vsRuns, 2);
    check("frame_start_pulses_in_two_frames", fsCount, 2);
    check("rgb_nonzero_while_blanked", blankRgbErr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
